// File: rtl/dac_spi_frame_gen_if.sv
// dac_spi_frame_gen_if: bundle between the training controller, the frame generator and the DAC serialiser.
interface dac_spi_frame_gen_if;
   logic        key_state_i;
   logic        en_dac_i;
   logic [15:0] data_in_i;
   logic [15:0] data_sdi_o;
   logic        cs_o;
   logic        sck_o;
   logic [4:0]  cnt_sck_o;
   logic        busy_o;
   logic        done_o;
   logic        dropped_o;
   modport master (
      output key_state_i, en_dac_i, data_in_i,
      input  data_sdi_o, cs_o, sck_o, cnt_sck_o, busy_o, done_o, dropped_o
   );
   modport slave (
      input  key_state_i, en_dac_i, data_in_i,
      output data_sdi_o, cs_o, sck_o, cnt_sck_o, busy_o, done_o, dropped_o
   );
endinterface

// File: rtl/dac_spi_frame_gen.sv
// dac_spi_frame_gen: SPI frame/timing generator driving the 16-bit DAC serialiser.
// Define DAC_PENDING_EN for a one-entry buffer that queues a start issued while busy.
module dac_spi_frame_gen #(
   parameter int SCK_DIV  = 2,
   parameter int CS_SETUP = 2,
   parameter int LDAC_GAP = 16
) (
   input  logic               clk,
   input  logic               rst,
   dac_spi_frame_gen_if.slave bus
);
   localparam int TMAX = (SCK_DIV > CS_SETUP) ? ((SCK_DIV > LDAC_GAP) ? SCK_DIV : LDAC_GAP)
                                              : ((CS_SETUP > LDAC_GAP) ? CS_SETUP : LDAC_GAP);
   localparam int TW = (TMAX > 1) ? $clog2(TMAX) : 1;
   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;
   state_t        state_q, state_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [4:0]    cnt_q, cnt_d;
   logic [15:0]   sdi_q, sdi_d;
   logic          cs_q, cs_d, sck_q, sck_d, busy_q, busy_d, done_q, done_d, drop_q, drop_d;
   logic          req, last, start;
   logic [15:0]   code;
`ifdef DAC_PENDING_EN
   logic [15:0]   pend_q, pend_d;
   logic          pv_q, pv_d;
`endif
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q + 1'b1;
      cnt_d   = cnt_q;
      sdi_d   = sdi_q;
      cs_d    = cs_q;
      sck_d   = sck_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      drop_d  = drop_q;
      req     = bus.en_dac_i && bus.key_state_i;
      last    = state_q == GAP && tmr_q == TW'(LDAC_GAP - 1);
      start   = state_q == IDLE && req;
      code    = bus.data_in_i;
`ifdef DAC_PENDING_EN
      pend_d  = pend_q;
      pv_d    = pv_q;
      if (last) begin
         start  = pv_q || req;
         code   = pv_q ? pend_q : bus.data_in_i;
         pv_d   = pv_q && req;
         pend_d = req ? bus.data_in_i : pend_q;
      end else if (req && busy_q) begin
         pv_d   = 1'b1;
         pend_d = pv_q ? pend_q : bus.data_in_i;
         drop_d = drop_q | pv_q;
      end
`else
      if (req && busy_q) drop_d = 1'b1;
`endif
      case (state_q)
         IDLE: tmr_d = '0;
         SETUP: if (tmr_q == TW'(CS_SETUP - 1)) begin
            state_d = SHIFT;
            tmr_d   = '0;
         end
         SHIFT: if (tmr_q == TW'(SCK_DIV - 1)) begin
            tmr_d = '0;
            sck_d = ~sck_q;
            // the falling edge closes bit cnt_q; cs rises together with the last fall
            if (sck_q) begin
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd15) begin
                  cs_d    = 1'b1;
                  state_d = GAP;
               end
            end
         end
         GAP: begin
            done_d = tmr_q == TW'(LDAC_GAP - 2);
            if (last) begin
               state_d = IDLE;
               tmr_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      if (start) begin
         state_d = SETUP;
         tmr_d   = '0;
         sdi_d   = code;
         busy_d  = 1'b1;
         cs_d    = 1'b0;
         sck_d   = 1'b0;
         cnt_d   = '0;
      end
      if (!bus.key_state_i) begin
         state_d = IDLE;
         tmr_d   = '0;
         cs_d    = 1'b1;
         sck_d   = 1'b0;
         cnt_d   = '0;
         busy_d  = 1'b0;
         done_d  = 1'b0;
         drop_d  = 1'b0;
`ifdef DAC_PENDING_EN
         pv_d    = 1'b0;
`endif
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         tmr_q   <= '0;
         cnt_q   <= '0;
         sdi_q   <= '0;
         cs_q    <= 1'b1;
         sck_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         cnt_q   <= cnt_d;
         sdi_q   <= sdi_d;
         cs_q    <= cs_d;
         sck_q   <= sck_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         drop_q  <= drop_d;
      end
   end
`ifdef DAC_PENDING_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q <= '0;
         pv_q   <= 1'b0;
      end else begin
         pend_q <= pend_d;
         pv_q   <= pv_d;
      end
   end
`endif
   assign bus.data_sdi_o = sdi_q;
   assign bus.cs_o       = cs_q;
   assign bus.sck_o      = sck_q;
   assign bus.cnt_sck_o  = cnt_q;
   assign bus.busy_o     = busy_q;
   assign bus.done_o     = done_q;
   assign bus.dropped_o  = drop_q;
endmodule
